slave_port: RTL and testbench
=============================

# slave_port

Slave-end controller for the bit-serial system bus. Each slave owns one instance, which sits directly behind the bus mux output that feeds that slave. The block deserialises the address, burst length and write data streamed by the granted master, and drives a simple synchronous local-memory interface. For reads it serialises the returned words back to the master, with master back-pressure.

## Interface
- ADDR_W, 12, address bits shifted per transaction
- DATA_W, 8, data bits per word
- BURST_W, 4, burst-length field bits; must be ≤ ADDR_W; words per transaction = field+1
- MEM_DEPTH, 4096, implemented words; used only by the range check
- clk  in  1  bus clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- master_valid  in  1  master is driving a transaction; low mid-transaction aborts it
- master_ready  in  1  master accepts the current rx_data bit
- read_en  in  1  read request, sampled at start
- write_en  in  1  write request, sampled at start
- tx_address  in  1  serial address, LSB first
- tx_burst  in  1  serial burst length, LSB first, concurrent with the first BURST_W address bits
- tx_data  in  1  serial write data, LSB first
- slave_ready  out  1  high only in IDLE
- slave_valid  out  1  rx_data holds a valid read bit
- rx_data  out  1  serial read data, LSB first
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle range-error pulse; present only with SLAVE_PORT_RANGE_CHECK_EN
- mem_addr  out  ADDR_W  local memory address
- mem_wdata  out  DATA_W  local memory write data
- mem_we  out  1  one-cycle write strobe
- mem_re  out  1  one-cycle read strobe; mem_rdata is valid on the next edge
- mem_rdata  in  DATA_W  local memory read data

## Operation
- **States:** IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RDATA, DONE.
- **Start (IDLE).** A transaction starts when master_valid=1 and exactly one of read_en/write_en is 1.
  - Address bit 0 and burst bit 0 are captured in the start cycle.
  - Next state is ADDR.
  - If read_en and write_en are both 1, the request is ignored and the block stays in IDLE.
- **ADDR.** Shifts the remaining ADDR_W-1 address bits, one per cycle; burst bits are taken in the first BURST_W-1 of these cycles.
  - After the last address bit, go to WDATA for a write or RREQ for a read.
- **WDATA.** Shifts DATA_W bits of tx_data, then goes to WRITE.
- **WRITE.** mem_we=1 for one cycle. tx_data is ignored in this cycle, so the master inserts one gap cycle between words.
  - If words remain: mem_addr increments, next state WDATA. Otherwise next state DONE.
- **RREQ.** mem_re=1 for one cycle, then RWAIT.
- **RWAIT.** Loads mem_rdata into the shift register, then RDATA.
- **RDATA.** slave_valid=1 and rx_data = current bit. The register shifts only in cycles where master_ready=1.
  - After DATA_W accepted bits: if words remain, mem_addr increments and the next state is RREQ; otherwise DONE.
- **DONE.** done=1 for one cycle, then IDLE.
- **Address arithmetic:** increments modulo 2^ADDR_W; wrap from all-ones to 0 is legal.
- **Abort:** master_valid=0 in ADDR, WDATA, WRITE, RREQ, RWAIT or RDATA returns the block to IDLE on the next edge.
  - No done pulse is issued.
  - A partially shifted word is never written.
  - A mem_we already asserted in the current cycle completes.
- **Reset mid-operation:** immediately returns to IDLE. No pending write is issued.

## Timing
- **Reset values:** state=IDLE, slave_ready=1, every other output 0, mem_addr=0, mem_wdata=0.
- **Outputs:** all decoded from registered state (Moore). No combinational path from input to output.
- **Single-word write:** start at T0; address bits T0..T(ADDR_W-1); data bits next DATA_W cycles; mem_we at T(ADDR_W+DATA_W); done one cycle later; slave_ready one cycle after that.
- **Single-word read:** mem_re at T(ADDR_W); rx_data bit 0 valid at T(ADDR_W+2); with master_ready held high, done at T(ADDR_W+2+DATA_W).
- **Read burst:** each extra word adds DATA_W+2 cycles, plus any cycles stalled by master_ready=0.
- **Write burst:** each extra word adds DATA_W+1 cycles.

## Configuration
- **SLAVE_PORT_RANGE_CHECK_EN defined:**
  - Checked on entering WRITE and RREQ: if mem_addr ≥ MEM_DEPTH, no mem_we/mem_re is issued.
  - err=1 for one cycle, then DONE without a done pulse, then IDLE.
  - The remaining words of the burst are dropped.
- **Not defined:** the err port is absent and every address is accessed.

## Test plan
- **Single write, defaults:** address 0x0A5, burst 0, data 0x3C → mem_we=1 with mem_addr=0x0A5 and mem_wdata=0x3C at T20; done at T21; slave_ready=1 at T22.
- **Read burst of 3 from 0xFFF, master_ready high, memory returns 0x11/0x22/0x33:** mem_addr sequence 0xFFF, 0x000, 0x001 (wrap); rx_data streams 0x11, 0x22, 0x33 LSB first; single done pulse.
- **Back-pressure:** read where master_ready=0 for 5 cycles mid-word → rx_data holds its bit and slave_valid stays 1; done is delayed exactly 5 cycles.
- **Abort and illegal request:**
  - master_valid dropped after 4 data bits of a write → no mem_we, no done, IDLE next cycle.
  - read_en=write_en=1 → stays in IDLE.
- **Async reset during RDATA:** slave_valid=0, slave_ready=1 and mem_re=0 immediately, with no clock edge needed.
- **With SLAVE_PORT_RANGE_CHECK_EN and MEM_DEPTH=1024:** write to 0x400 → err pulse, no mem_we, no done.

Source files
------------

// File: rtl/slave_port.sv
// Slave-end bit-serial bus controller: deserialises address/burst/write data, drives a local memory, serialises reads.
// Optional SLAVE_PORT_RANGE_CHECK_EN adds the err port and suppresses accesses at or above MEM_DEPTH.
module slave_port #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int BURST_W   = 4,
  parameter int MEM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              master_valid,
  input  logic              master_ready,
  input  logic              read_en,
  input  logic              write_en,
  input  logic              tx_address,
  input  logic              tx_burst,
  input  logic              tx_data,
  output logic              slave_ready,
  output logic              slave_valid,
  output logic              rx_data,
  output logic              done,
`ifdef SLAVE_PORT_RANGE_CHECK_EN
  output logic              err,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int MAXW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAXW) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_RREQ, S_RWAIT, S_RDATA, S_DONE
  } state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_shift;
  logic [BURST_W-1:0]  r_burst;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_is_rd;

  logic w_start, w_last_addr, w_last_data, w_more, w_oor;

  assign w_start     = master_valid & (read_en ^ write_en);
  assign w_last_addr = (r_cnt == CNT_W'(ADDR_W - 1));
  assign w_last_data = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_more      = (r_burst != '0);

`ifdef SLAVE_PORT_RANGE_CHECK_EN
  // mem_addr is stable across WRITE/RREQ and the following DONE, so one compare covers err and done suppression
  assign w_oor = (32'(r_mem_addr) >= 32'(MEM_DEPTH));
  assign err   = ((r_state == S_WRITE) || (r_state == S_RREQ)) && w_oor;
`else
  assign w_oor = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_ADDR;
      S_ADDR:  if (!master_valid) w_next = S_IDLE;
               else if (w_last_addr) w_next = r_is_rd ? S_RREQ : S_WDATA;
      S_WDATA: if (!master_valid) w_next = S_IDLE;
               else if (w_last_data) w_next = S_WRITE;
      S_WRITE: if (!master_valid) w_next = S_IDLE;
               else if (w_oor || !w_more) w_next = S_DONE;
               else w_next = S_WDATA;
      S_RREQ:  if (!master_valid) w_next = S_IDLE;
               else if (w_oor) w_next = S_DONE;
               else w_next = S_RWAIT;
      S_RWAIT: if (!master_valid) w_next = S_IDLE;
               else w_next = S_RDATA;
      S_RDATA: if (!master_valid) w_next = S_IDLE;
               else if (master_ready && w_last_data) w_next = w_more ? S_RREQ : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_shift     <= '0;
      r_burst     <= '0;
      r_cnt       <= '0;
      r_is_rd     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_mem_addr <= {tx_address, r_mem_addr[ADDR_W-1:1]};
          r_burst    <= (r_burst >> 1) | (BURST_W'(tx_burst) << (BURST_W - 1));
          r_cnt      <= CNT_W'(1);
          r_is_rd    <= read_en;
        end
        S_ADDR: begin
          r_mem_addr <= {tx_address, r_mem_addr[ADDR_W-1:1]};
          if (r_cnt < CNT_W'(BURST_W))
            r_burst <= (r_burst >> 1) | (BURST_W'(tx_burst) << (BURST_W - 1));
          r_cnt <= w_last_addr ? '0 : r_cnt + 1'b1;
        end
        S_WDATA: begin
          r_mem_wdata <= {tx_data, r_mem_wdata[DATA_W-1:1]};
          r_cnt       <= w_last_data ? '0 : r_cnt + 1'b1;
        end
        S_WRITE: if (master_valid && !w_oor && w_more) begin
          r_mem_addr <= r_mem_addr + 1'b1;
          r_burst    <= r_burst - 1'b1;
        end
        S_RWAIT: r_shift <= mem_rdata;
        S_RDATA: if (master_ready) begin
          r_shift <= r_shift >> 1;
          r_cnt   <= w_last_data ? '0 : r_cnt + 1'b1;
          if (w_last_data && w_more) begin
            r_mem_addr <= r_mem_addr + 1'b1;
            r_burst    <= r_burst - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign slave_ready = (r_state == S_IDLE);
  assign slave_valid = (r_state == S_RDATA);
  assign rx_data     = (r_state == S_RDATA) & r_shift[0];
  assign done        = (r_state == S_DONE) & ~w_oor;
  assign mem_we      = (r_state == S_WRITE) & ~w_oor;
  assign mem_re      = (r_state == S_RREQ) & ~w_oor;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port with a write/read scoreboard and a simple synchronous memory model.
module tb_slave_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int BW = 4;
`ifdef SLAVE_PORT_RANGE_CHECK_EN
  localparam int DEPTH = 1024;
`else
  localparam int DEPTH = 4096;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic master_valid = 0, master_ready = 0, read_en = 0, write_en = 0;
  logic tx_address = 0, tx_burst = 0, tx_data = 0;
  logic slave_ready, slave_valid, rx_data, done, mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef SLAVE_PORT_RANGE_CHECK_EN
  logic err;
`endif

  slave_port #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .master_valid(master_valid), .master_ready(master_ready),
    .read_en(read_en), .write_en(write_en), .tx_address(tx_address), .tx_burst(tx_burst),
    .tx_data(tx_data), .slave_ready(slave_ready), .slave_valid(slave_valid), .rx_data(rx_data),
    .done(done),
`ifdef SLAVE_PORT_RANGE_CHECK_EN
    .err(err),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  int            checks = 0;
  int            failures = 0;
  wr_t           q_wr[$];
  logic [AW-1:0] q_ra[$];
  logic [DW-1:0] q_rd[$];
  logic [DW-1:0] tbmem [0:(1<<AW)-1];
  int            done_cnt = 0;
  int            rx_bit = 0;
  logic [DW-1:0] rx_word = '0;
  wr_t           mon_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) if (mem_re) mem_rdata <= tbmem[mem_addr];

  // scoreboard side: pop expectations as the DUT produces strobes and read words
  always @(negedge clk) begin
    if (rst) rx_bit = 0;
    else begin
      if (mem_we) begin
        if (q_wr.size() == 0) chk("unexpected_we", 32'(1), 32'(0));
        else begin
          mon_w = q_wr.pop_front();
          chk("we_addr", 32'(mem_addr), 32'(mon_w.a));
          chk("we_data", 32'(mem_wdata), 32'(mon_w.d));
        end
      end
      if (mem_re) begin
        if (q_ra.size() == 0) chk("unexpected_re", 32'(1), 32'(0));
        else chk("re_addr", 32'(mem_addr), 32'(q_ra.pop_front()));
      end
      if (slave_valid && master_ready) begin
        rx_word[rx_bit] = rx_data;
        if (rx_bit == DW - 1) begin
          rx_bit = 0;
          if (q_rd.size() == 0) chk("unexpected_rx", 32'(1), 32'(0));
          else chk("rx_word", 32'(rx_word), 32'(q_rd.pop_front()));
        end else rx_bit++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic clk1();
    @(posedge clk); #1;
  endtask

  task automatic hdr(input logic rd, input logic [AW-1:0] a, input logic [BW-1:0] b);
    master_valid = 1; read_en = rd; write_en = !rd;
    for (int i = 0; i < AW; i++) begin
      tx_address = a[i];
      tx_burst   = (i < BW) ? b[i] : 1'b0;
      clk1();
    end
    read_en = 0; write_en = 0;
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    for (int i = 0; i < DW; i++) begin
      tx_data = d[i];
      clk1();
    end
  endtask

  // leaves the caller at the negedge of the done cycle, or at posedge+1 on timeout
  task automatic wait_done(input int exp_cyc, input string tag);
    bit seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin
        chk(tag, 32'(n), 32'(exp_cyc));
        seen = 1;
        break;
      end
      clk1();
    end
    if (!seen) chk({tag, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input int nw, input logic [DW-1:0] base);
    logic [DW-1:0] d;
    hdr(0, a, BW'(nw - 1));
    for (int w = 0; w < nw; w++) begin
      d = base + DW'(w * 8'h69);
      q_wr.push_back('{a + AW'(w), d});
      send_word(d);
      tx_data = 1'($urandom_range(1));
      clk1();
    end
    @(negedge clk);
    chk("wrb_done", 32'(done), 32'(1));
    master_valid = 0;
    clk1();
  endtask

  initial begin
    int d0;
    logic [DW-1:0] v;

    #2;
    chk("rst_ready", 32'(slave_ready), 32'(1));
    chk("rst_valid", 32'(slave_valid), 32'(0));
    chk("rst_rx", 32'(rx_data), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_we_re", 32'({mem_we, mem_re}), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_wdata", 32'(mem_wdata), 32'(0));
    @(posedge clk); #1 rst = 0;
    clk1();

    // single write 0x0A5 <= 0x3C, exact cycle timing
    q_wr.push_back('{12'h0A5, 8'h3C});
    hdr(0, 12'h0A5, 4'd0);
    send_word(8'h3C);
    tx_data = 1;
    @(negedge clk);
    chk("w1_we_T20", 32'(mem_we), 32'(1));
    chk("w1_addr", 32'(mem_addr), 32'(12'h0A5));
    chk("w1_data", 32'(mem_wdata), 32'(8'h3C));
    clk1();
    @(negedge clk);
    chk("w1_done_T21", 32'(done), 32'(1));
    chk("w1_busy_T21", 32'(slave_ready), 32'(0));
    master_valid = 0;
    clk1();
    @(negedge clk);
    chk("w1_ready_T22", 32'(slave_ready), 32'(1));
    clk1();

    // write burst across the address wrap
    wr_burst(12'hFFE, 3, 8'hA1);

    // read burst of 3 from 0xFFF with wrap
    tbmem[12'hFFF] = 8'h11; tbmem[12'h000] = 8'h22; tbmem[12'h001] = 8'h33;
    q_ra.push_back(12'hFFF); q_ra.push_back(12'h000); q_ra.push_back(12'h001);
    q_rd.push_back(8'h11); q_rd.push_back(8'h22); q_rd.push_back(8'h33);
    master_ready = 1;
    d0 = done_cnt;
    hdr(1, 12'hFFF, 4'd2);
    wait_done(3 * (DW + 2), "rd3_done_lat");
    clk1();
    master_valid = 0;
    clk1();
    @(negedge clk);
    chk("rd3_one_done", 32'(done_cnt - d0), 32'(1));
    chk("rd3_q_empty", 32'(q_rd.size()), 32'(0));
    clk1();

    // back-pressure: 5 stalled cycles after bit 1
    tbmem[12'h010] = 8'hA5;
    v = 8'hA5;
    q_ra.push_back(12'h010); q_rd.push_back(8'hA5);
    hdr(1, 12'h010, 4'd0);
    clk1(); clk1(); clk1(); clk1();
    master_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(slave_valid), 32'(1));
      chk("bp_hold", 32'(rx_data), 32'(v[2]));
      clk1();
    end
    master_ready = 1;
    wait_done(6, "bp_done_lat");
    clk1();
    master_valid = 0;
    clk1();

    // abort after 4 write data bits
    d0 = done_cnt;
    hdr(0, 12'h055, 4'd0);
    for (int i = 0; i < 4; i++) begin tx_data = 1; clk1(); end
    master_valid = 0;
    clk1();
    @(negedge clk);
    chk("abort_idle", 32'(slave_ready), 32'(1));
    repeat (4) clk1();
    chk("abort_no_done", 32'(done_cnt - d0), 32'(0));

    // read_en and write_en together are ignored
    master_valid = 1; read_en = 1; write_en = 1;
    for (int i = 0; i < 4; i++) begin
      clk1();
      @(negedge clk);
      chk("illegal_idle", 32'(slave_ready), 32'(1));
    end
    master_valid = 0; read_en = 0; write_en = 0;
    clk1();

    // asynchronous reset while in RDATA
    tbmem[12'h020] = 8'h96;
    q_ra.push_back(12'h020);
    master_ready = 0;
    hdr(1, 12'h020, 4'd0);
    clk1(); clk1();
    @(negedge clk);
    chk("ar_in_rdata", 32'(slave_valid), 32'(1));
    #2 rst = 1;
    #1;
    chk("ar_valid", 32'(slave_valid), 32'(0));
    chk("ar_ready", 32'(slave_ready), 32'(1));
    chk("ar_re", 32'(mem_re), 32'(0));
    chk("ar_rx", 32'(rx_data), 32'(0));
    master_valid = 0;
    master_ready = 1;
    @(posedge clk); #1 rst = 0;
    clk1();

`ifdef SLAVE_PORT_RANGE_CHECK_EN
    d0 = done_cnt;
    hdr(0, 12'h400, 4'd0);
    send_word(8'h77);
    @(negedge clk);
    chk("rc_err", 32'(err), 32'(1));
    chk("rc_no_we", 32'(mem_we), 32'(0));
    clk1();
    @(negedge clk);
    chk("rc_no_done", 32'(done), 32'(0));
    master_valid = 0;
    clk1();
    @(negedge clk);
    chk("rc_idle", 32'(slave_ready), 32'(1));
    chk("rc_done_cnt", 32'(done_cnt - d0), 32'(0));
    clk1();
`endif

    chk("end_wr_q", 32'(q_wr.size()), 32'(0));
    chk("end_ra_q", 32'(q_ra.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
